// File: rtl/ifetch_pkg.sv
// Shared constants and state type for the instruction fetch stage.
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        ERR
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the fetch cache: combinational read by index,
// clocked write, and a clear of every valid bit on flush.
module icache_array #(
    parameter int LINES = 16,
    parameter int TAG_W = 26,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES];

    // Flush takes priority over a fill landing in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < LINES; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) valid[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LINES; i++) begin
            if (wr_en && !flush && wr_idx == IDX_W'(i)) begin
                tags[i] <= wr_tag;
                data[i] <= wr_data;
            end
        end
    end

    // Compare-based select keeps a one-line array free of out-of-range indexing.
    always_comb begin
        rd_valid = 1'b0;
        rd_tag   = '0;
        rd_data  = '0;
        for (int i = 0; i < LINES; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_valid = valid[i];
                rd_tag   = tags[i];
                rd_data  = data[i];
            end
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: cache lookup, miss FSM towards instruction memory.
// Define IFETCH_ICACHE_EN for a NUM_LINES direct-mapped cache; otherwise a single-entry buffer.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int NUM_LINES = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        stall,
    output logic        fetch_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err
);

    if (NUM_LINES < 2 || (NUM_LINES & (NUM_LINES - 1)) != 0) begin : g_num_lines_check
        $error("ifetch: NUM_LINES must be a power of two and at least 2");
    end

`ifdef IFETCH_ICACHE_EN
    localparam int LINES = NUM_LINES;
    localparam int IW    = $clog2(NUM_LINES);
`else
    localparam int LINES = 1;
    localparam int IW    = 0;
`endif
    localparam int TAG_W = 30 - IW;
    localparam int IDX_W = (IW > 0) ? IW : 1;

    fetch_state_t     state, state_next;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_data;
    logic             hit;
    logic             misaligned;
    logic             fill;

`ifdef IFETCH_ICACHE_EN
    assign idx = pc[2+IW-1:2];
`else
    assign idx = '0;
`endif
    assign tag        = pc[31:2+IW];
    assign hit        = line_valid && (line_tag == tag);
    assign misaligned = is_misaligned(pc[1:0]);
    assign mem_addr   = {pc[31:2], 2'b00};

    icache_array #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_array (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (fill),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (mem_rsp_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // pc is held while stalled, so the fill reuses the live index and tag.
    always_comb begin
        state_next    = state;
        instr         = NOP_INSTR;
        stall         = 1'b0;
        fetch_err     = 1'b0;
        mem_req_valid = 1'b0;
        fill          = 1'b0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    fetch_err = 1'b1;
                end else if (hit) begin
                    instr = line_data;
                end else begin
                    stall      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        state_next = ERR;
                    end else begin
                        fill       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            ERR: begin
                fetch_err  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a per-cycle reference model of the fetch rules.
module tb_ifetch;

    localparam int NUM_LINES = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFETCH_ICACHE_EN
    localparam int M_LINES = NUM_LINES;
`else
    localparam int M_LINES = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic        mem_req_ready = 1'b1;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        mem_rsp_err = 1'b0;
    logic [31:0] instr;
    logic        stall;
    logic        fetch_err;
    logic        mem_req_valid;
    logic [31:0] mem_addr;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    ifetch #(.NUM_LINES(NUM_LINES)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pc            (pc),
        .flush         (flush),
        .instr         (instr),
        .stall         (stall),
        .fetch_err     (fetch_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which word addresses are held, and where the fetch is.
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_ERR = 3;
    int          m_phase = P_IDLE;
    bit          m_valid [M_LINES];
    logic [29:0] m_word  [M_LINES];
    logic [31:0] m_data  [M_LINES];
    int          m_ln;
    bit          m_fill;

    function automatic int line_of(input logic [31:0] a);
        return int'(a[31:2]) % M_LINES;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[line_of(a)] && m_word[line_of(a)] == a[31:2];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase = P_IDLE;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else begin
            m_ln   = line_of(pc);
            m_fill = 1'b0;
            case (m_phase)
                P_IDLE: if (pc[1:0] == 2'b00 && !m_hit(pc)) m_phase = P_REQ;
                P_REQ:  if (mem_req_ready) m_phase = P_WAIT;
                P_WAIT: if (mem_rsp_valid) begin
                    m_phase = mem_rsp_err ? P_ERR : P_IDLE;
                    m_fill  = !mem_rsp_err && !flush;
                end
                default: m_phase = P_IDLE;
            endcase
            if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
            if (m_fill) begin
                m_valid[m_ln] = 1'b1;
                m_word[m_ln]  = pc[31:2];
                m_data[m_ln]  = mem_rsp_data;
            end
        end
    end

    logic [31:0] e_instr;
    logic        e_stall, e_err, e_rv;

    always @(negedge clk) begin
        if (chk_en) begin
            e_instr = NOP;
            e_stall = 1'b0;
            e_err   = 1'b0;
            e_rv    = 1'b0;
            case (m_phase)
                P_IDLE: begin
                    if (pc[1:0] != 2'b00)  e_err = 1'b1;
                    else if (m_hit(pc))    e_instr = m_data[line_of(pc)];
                    else                   e_stall = 1'b1;
                end
                P_REQ:  begin e_stall = 1'b1; e_rv = 1'b1; end
                P_WAIT: e_stall = 1'b1;
                default: e_err = 1'b1;
            endcase
            chk1("model_stall", stall, e_stall);
            chk32("model_instr", instr, e_instr);
            chk1("model_fetch_err", fetch_err, e_err);
            chk1("model_req_valid", mem_req_valid, e_rv);
            if (e_rv) chk32("model_mem_addr", mem_addr, {pc[31:2], 2'b00});
        end
    end

    // Drives one fetch and plays the memory side until stall drops.
    task automatic do_fetch(input logic [31:0] a, input int rdy_lat, input int rsp_lat,
                            input logic [31:0] data, input bit err, input bit flush_once,
                            output int stalls, output int hs,
                            output logic [31:0] f_instr, output logic f_err);
        int wait_cnt, rdy_cnt;
        bit pending, hs_now, req_seen, done, fl;
        @(posedge clk); #1;
        pc = a;
        rdy_cnt = rdy_lat;
        mem_req_ready = (rdy_cnt == 0);
        stalls = 0; hs = 0; pending = 1'b0; done = 1'b0; fl = flush_once; wait_cnt = 0;
        f_instr = 32'hx; f_err = 1'bx;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                f_instr = instr;
                f_err = fetch_err;
            end else begin
                stalls++;
                hs_now = mem_req_valid && mem_req_ready;
                req_seen = mem_req_valid;
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0;
                flush = 1'b0;
                if (hs_now) begin hs++; pending = 1'b1; wait_cnt = rsp_lat; end
                if (pending) begin
                    wait_cnt--;
                    if (wait_cnt <= 0) begin
                        pending = 1'b0;
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data = data;
                        mem_rsp_err = err;
                        flush = fl;
                        fl = 1'b0;
                    end
                end
                if (req_seen && !hs_now && rdy_cnt > 0) rdy_cnt--;
                mem_req_ready = (rdy_cnt == 0);
            end
        end
        chk1("fetch_completed", done, 1'b1);
    endtask

    int          n_stall, n_hs;
    logic [31:0] r_instr;
    logic        r_err;

    initial begin
        #1 rstn = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk1("reset_stall", stall, 1'b1);
        chk32("reset_instr", instr, NOP);
        chk1("reset_req_valid", mem_req_valid, 1'b0);
        chk1("reset_fetch_err", fetch_err, 1'b0);
        @(posedge clk); #1;
        pc = 32'h2;
        rstn = 1'b1;

        do_fetch(32'h0, 0, 1, 32'h0050_0093, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("first_miss_stalls", n_stall, 3);
        chk32("first_miss_handshakes", n_hs, 1);
        chk32("first_miss_instr", r_instr, 32'h0050_0093);

        do_fetch(32'h0, 0, 1, 32'h0, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("refetch_hit_stalls", n_stall, 0);
        chk32("refetch_hit_handshakes", n_hs, 0);
        chk32("refetch_hit_instr", r_instr, 32'h0050_0093);

        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk1("flush_cycle_hit_stall", stall, 1'b0);
        chk32("flush_cycle_hit_instr", instr, 32'h0050_0093);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk1("after_flush_miss", stall, 1'b1);
        do_fetch(32'h0, 0, 1, 32'h0050_0093, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("after_flush_refill_instr", r_instr, 32'h0050_0093);

        do_fetch(32'h40, 0, 1, 32'h0aa0_0093, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("fill_40_stalls", n_stall, 3);
        do_fetch(32'h40 + 4 * NUM_LINES, 0, 1, 32'h0bb0_0113, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("evict_stalls", n_stall, 3);
        chk32("evict_instr", r_instr, 32'h0bb0_0113);
        do_fetch(32'h40, 0, 1, 32'h0aa0_0093, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("return_40_handshakes", n_hs, 1);
        chk32("return_40_instr", r_instr, 32'h0aa0_0093);

        do_fetch(32'h300, 4, 1, 32'h00c0_0193, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("ready_low_stalls", n_stall, 7);
        chk32("ready_low_handshakes", n_hs, 1);
        chk32("ready_low_instr", r_instr, 32'h00c0_0193);

        do_fetch(32'h304, 0, 3, 32'h00d0_0213, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("slow_rsp_stalls", n_stall, 5);

        do_fetch(32'h6, 0, 1, 32'h0, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("misaligned_stalls", n_stall, 0);
        chk32("misaligned_handshakes", n_hs, 0);
        chk1("misaligned_err", r_err, 1'b1);
        chk32("misaligned_instr", r_instr, NOP);

        do_fetch(32'h500, 0, 1, 32'h00e0_0293, 1'b1, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("bus_err_stalls", n_stall, 3);
        chk1("bus_err_flag", r_err, 1'b1);
        chk32("bus_err_instr", r_instr, NOP);
        do_fetch(32'h500, 0, 1, 32'h00e0_0293, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("after_err_refetch_handshakes", n_hs, 1);
        chk32("after_err_refetch_instr", r_instr, 32'h00e0_0293);

        do_fetch(32'h600, 0, 1, 32'h00f0_0313, 1'b0, 1'b1, n_stall, n_hs, r_instr, r_err);
        chk32("flush_on_fill_stalls", n_stall, 6);
        chk32("flush_on_fill_handshakes", n_hs, 2);
        chk32("flush_on_fill_instr", r_instr, 32'h00f0_0313);

        @(posedge clk); #1;
        pc = 32'h100;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk1("wait_state_stall", stall, 1'b1);
        chk1("wait_state_req_valid", mem_req_valid, 1'b0);
        #2 rstn = 1'b0;
        pc = 32'h102;
        #1;
        chk1("mid_miss_reset_req_valid", mem_req_valid, 1'b0);
        chk1("mid_miss_reset_stall", stall, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hdead_beef;
        mem_rsp_err = 1'b0;
        @(negedge clk);
        chk1("late_rsp_fetch_err", fetch_err, 1'b1);
        chk32("late_rsp_instr", instr, NOP);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        do_fetch(32'h100, 0, 1, 32'h1111_1111, 1'b0, 1'b0, n_stall, n_hs, r_instr, r_err);
        chk32("after_late_rsp_stalls", n_stall, 3);
        chk32("after_late_rsp_instr", r_instr, 32'h1111_1111);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage between the PC register and the decoder. It takes the current `pc` and returns the 32-bit instruction at that address, served from a small direct-mapped instruction cache or from instruction memory over a valid/ready request and response interface. While a fetch is outstanding it raises `stall`, which freezes the PC register and blocks writeback. Misaligned PCs and memory errors are reported as faults.

## Interface
- `NUM_LINES`, 16: number of cache lines, one 32-bit word each. Power of two, at least 2.
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `pc`  in  32  current fetch address. Stable while `stall`=1.
- `flush`  in  1  invalidate all cache lines (fence.i)
- `instr`  out  32  fetched instruction; NOP (32'h00000013) when not valid
- `stall`  out  1  fetch not complete; PC must hold
- `fetch_err`  out  1  misaligned PC or memory error, for this cycle only
- `mem_req_valid`  out  1  memory request valid
- `mem_req_ready`  in  1  memory accepts the request
- `mem_addr`  out  32  word-aligned request address
- `mem_rsp_valid`  in  1  response valid (no backpressure)
- `mem_rsp_data`  in  32  response instruction word
- `mem_rsp_err`  in  1  response carries a bus error

## Operation
- Address split:
  - index = `pc`[2+IW-1:2], with IW = log2(`NUM_LINES`)
  - tag = `pc`[31:2+IW]
- Misaligned (`pc`[1:0] != 0) in IDLE:
  - `instr` = NOP, `fetch_err` = 1, `stall` = 0
  - No memory request and no state change.
- Hit (IDLE, line valid, tag equal): combinational. `instr` = line data, `stall` = 0.
- Miss in IDLE: `stall` = 1 in the same cycle; next state REQ.
- REQ:
  - `mem_req_valid` = 1 and `mem_addr` = {`pc`[31:2], 2'b00}, both held until `mem_req_ready`.
  - On `mem_req_ready`, go to WAIT.
- WAIT:
  - `mem_rsp_valid` with no error: write the line (data, tag, valid = 1), then go to IDLE. The next cycle hits.
  - `mem_rsp_valid` with `mem_rsp_err`: no write; go to ERR.
- ERR (one cycle): `instr` = NOP, `fetch_err` = 1, `stall` = 0, then IDLE.
- `stall` = 1 in every REQ and WAIT cycle.
- `mem_rsp_valid` outside WAIT is ignored.
- `flush`:
  - Clears all valid bits on the next clock edge.
  - If a fill response arrives in the same cycle as `flush`, it is not written. The state still returns to IDLE, the lookup misses, and the word is fetched again.
  - In IDLE, the lookup in the `flush` cycle still uses the pre-flush contents.

## Timing
- Reset values:
  - state IDLE, all valid bits 0
  - `mem_req_valid` = 0, `fetch_err` = 0, `instr` = NOP
  - `stall` = 1 (pc misses an empty cache)
- Hit latency 0 cycles. Miss penalty = 1 + request wait + response wait + 1.
  - With `mem_req_ready` = 1 and the response one cycle after acceptance: 3 stall cycles.
- Memory contract: the response arrives at least one cycle after the request handshake, and only one request is outstanding.
- `rstn` asserted mid-miss: immediate return to IDLE with `mem_req_valid` = 0. A late response is ignored.

## Configuration
- `IFETCH_ICACHE_EN` defined:
  - Cache of `NUM_LINES` lines as described.
- Not defined:
  - Single-entry buffer. Holds the last fetched word with a full 30-bit tag (`pc`[31:2]) and one valid bit; `NUM_LINES` is ignored.
  - FSM, flush rules, error handling and timing are identical. Only the hit rate differs.

## Structure
- Package `ifetch_pkg`:
  - `NOP_INSTR` = 32'h00000013
  - `fetch_state_t` enum {IDLE, REQ, WAIT, ERR}
- Sub-module `icache_array`:
  - valid/tag/data storage
  - asynchronous read by index, synchronous write, synchronous clear-all on flush
  - Parameterised by lines and tag width, so it is reused unchanged for the single-entry build.
- FSM, address split and output muxing live in `ifetch`.

## Test plan
- Reset, then `pc` = 0; memory returns 32'h00500093 with ready = 1 and a 1-cycle response:
  - `stall` is high for 3 cycles; `mem_addr` = 0.
  - Then `instr` = 32'h00500093 and `stall` = 0.
  - A re-fetch of `pc` = 0 hits with no request.
- `pc` = 32'h40 fills, then `pc` = 32'h40 + 4·`NUM_LINES` (same index) misses and evicts:
  - Returning to 32'h40 issues a new request.
- `mem_req_ready` low for 4 cycles:
  - `mem_req_valid` and `mem_addr` stay stable; `stall` holds; exactly one handshake occurs.
- `pc` = 32'h6:
  - `fetch_err` = 1, `instr` = NOP, `stall` = 0, no request.
- Response with `mem_rsp_err` = 1:
  - One ERR cycle with `fetch_err` = 1 and NOP.
  - The line stays invalid; the next fetch of the same address misses.
- `flush` in the response cycle of a fill, and `rstn` pulsed during WAIT:
  - The line is not written; the state returns to IDLE.
  - A late response after reset causes no write and no output change.
